// File: rtl/square_plotter_if.sv
// Request/pixel bundle between the layout logic, the square plotter and the VGA adapter.
// The master side issues draw requests; the slave side (the plotter) drives the pixel stream.
interface square_plotter_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [1:0] req_size;
    logic [2:0] req_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       done;

    modport master (
        output req_valid, req_x, req_y, req_size, req_colour,
        input  req_ready, vga_x, vga_y, vga_colour, vga_plot, done
    );

    modport slave (
        input  req_valid, req_x, req_y, req_size, req_colour,
        output req_ready, vga_x, vga_y, vga_colour, vga_plot, done
    );
endinterface

// File: rtl/square_plotter.sv
// Draws one filled square per accepted request, one pixel per clock in row-major order,
// clipping against the visible screen and pulsing done when the square is complete.
module square_plotter #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int BIG_SIZE    = 20,
    parameter int MEDIUM_SIZE = 10,
    parameter int SMALL_SIZE  = 4
) (
    input  logic              clock,
    input  logic              reset,
    square_plotter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] bx_r, bx_s;
    logic [6:0] by_r, by_s;
    logic [2:0] colour_r, colour_s;
    logic [4:0] n_r, n_s;
    logic [4:0] col_r, col_s;
    logic [4:0] row_r, row_s;
    logic [7:0] vga_x_r, vga_x_s;
    logic [6:0] vga_y_r, vga_y_s;
    logic [2:0] vga_colour_r, vga_colour_s;
    logic       vga_plot_r, vga_plot_s;
    logic       done_r, done_s;
    logic [8:0] sum_x_s, sum_y_s;
    logic       last_col_s, last_row_s;

    function automatic logic [4:0] side_of(input logic [1:0] size);
        logic [4:0] n;
        case (size)
            2'd0:    n = 5'(SMALL_SIZE);
            2'd1:    n = 5'(MEDIUM_SIZE);
            2'd2:    n = 5'(BIG_SIZE);
            default: n = 5'd1;
        endcase
        return n;
    endfunction

    // Nine-bit sums keep off-screen coordinates from wrapping back into view.
    assign sum_x_s    = {1'b0, bx_r} + {4'b0000, col_r};
    assign sum_y_s    = {2'b00, by_r} + {4'b0000, row_r};
    assign last_col_s = (col_r == (n_r - 5'd1));
    assign last_row_s = (row_r == (n_r - 5'd1));

    assign bus.req_ready  = (state_r == IDLE) && !reset;
    assign bus.vga_x      = vga_x_r;
    assign bus.vga_y      = vga_y_r;
    assign bus.vga_colour = vga_colour_r;
    assign bus.vga_plot   = vga_plot_r;
    assign bus.done       = done_r;

    // Next-state, counter and pixel-output logic.
    always_comb begin
        state_s      = state_r;
        bx_s         = bx_r;
        by_s         = by_r;
        colour_s     = colour_r;
        n_s          = n_r;
        col_s        = col_r;
        row_s        = row_r;
        vga_x_s      = vga_x_r;
        vga_y_s      = vga_y_r;
        vga_colour_s = vga_colour_r;
        vga_plot_s   = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    bx_s     = bus.req_x;
                    by_s     = bus.req_y;
                    colour_s = bus.req_colour;
                    n_s      = side_of(bus.req_size);
                    col_s    = 5'd0;
                    row_s    = 5'd0;
                    state_s  = DRAW;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRAW: begin
                vga_x_s      = sum_x_s[7:0];
                vga_y_s      = sum_y_s[6:0];
                vga_colour_s = colour_r;
                vga_plot_s   = (sum_x_s < 9'(SCREEN_W)) && (sum_y_s < 9'(SCREEN_H));
                if (last_col_s) begin
                    col_s = 5'd0;
                    row_s = row_r + 5'd1;
                end else begin
                    col_s = col_r + 5'd1;
                end
                if (last_col_s && last_row_s) begin
                    state_s = FINISH;
                end else begin
                    state_s = DRAW;
                end
            end
            FINISH: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched request and registered VGA outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            bx_r         <= 8'd0;
            by_r         <= 7'd0;
            colour_r     <= 3'd0;
            n_r          <= 5'd0;
            col_r        <= 5'd0;
            row_r        <= 5'd0;
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 3'd0;
            vga_plot_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            bx_r         <= bx_s;
            by_r         <= by_s;
            colour_r     <= colour_s;
            n_r          <= n_s;
            col_r        <= col_s;
            row_r        <= row_s;
            vga_x_r      <= vga_x_s;
            vga_y_r      <= vga_y_s;
            vga_colour_r <= vga_colour_s;
            vga_plot_r   <= vga_plot_s;
            done_r       <= done_s;
        end
    end

endmodule

// File: tb/tb_square_plotter.sv
// Bench for square_plotter: a timeline model predicts every output cycle; directed
// scenarios plus randomized requests exercise drawing, clipping, back-to-back and reset.
module tb_square_plotter;

    logic clock = 1'b0;
    logic reset;

    square_plotter_if ifc ();

    square_plotter dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit plot;
        bit done;
        bit ready;
        bit hold;
        int x;
        int y;
        int c;
    } exp_t;

    typedef struct {
        int x;
        int y;
    } pix_t;

    exp_t mq[$];
    int   m_x = 0, m_y = 0, m_c = 0;
    bit   m_plot = 1'b0, m_done = 1'b0, m_ready = 1'b1;

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    pix_t plots[$];
    int   first_cyc = -1, done_cyc = -1, done_n = 0;

    function automatic int side(int s);
        case (s)
            0:       return 4;
            1:       return 10;
            2:       return 20;
            default: return 1;
        endcase
    endfunction

    // Expected output timeline for one accepted request, one entry per following edge.
    task automatic gen(int bx, int by, int s, int c);
        int   n;
        exp_t e;
        n = side(s);
        e.plot = 1'b0; e.done = 1'b0; e.ready = 1'b0; e.hold = 1'b1;
        e.x = 0; e.y = 0; e.c = 0;
        mq.push_back(e);
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k < n; k++) begin
                e.plot  = ((bx + k) < 160) && ((by + r) < 120);
                e.done  = 1'b0;
                e.ready = 1'b0;
                e.hold  = 1'b0;
                e.x     = (bx + k) % 256;
                e.y     = (by + r) % 128;
                e.c     = c;
                mq.push_back(e);
            end
        end
        e.plot = 1'b0; e.done = 1'b1; e.ready = 1'b1; e.hold = 1'b1;
        mq.push_back(e);
    endtask

    task automatic chk(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Edge counter.
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Reference model: advances the expected timeline on every edge.
    initial begin : model
        exp_t e;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                mq.delete();
                m_x = 0; m_y = 0; m_c = 0;
                m_plot = 1'b0; m_done = 1'b0; m_ready = 1'b1;
            end else begin
                if (mq.size() == 0 && ifc.req_valid === 1'b1)
                    gen(int'(ifc.req_x), int'(ifc.req_y), int'(ifc.req_size), int'(ifc.req_colour));
                if (mq.size() != 0) begin
                    e = mq.pop_front();
                end else begin
                    e.plot = 1'b0; e.done = 1'b0; e.ready = 1'b1; e.hold = 1'b1;
                end
                m_plot  = e.plot;
                m_done  = e.done;
                m_ready = e.ready;
                if (!e.hold) begin
                    m_x = e.x; m_y = e.y; m_c = e.c;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a record of plotted pixels and done pulses.
    initial begin : compare
        bit ep, ed, er;
        int ex, ey, ec;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                ep = 1'b0; ed = 1'b0; er = 1'b0; ex = 0; ey = 0; ec = 0;
            end else begin
                ep = m_plot; ed = m_done; er = m_ready; ex = m_x; ey = m_y; ec = m_c;
            end
            n_cmp++;
            if (ifc.vga_plot !== ep || ifc.done !== ed || ifc.req_ready !== er ||
                int'(ifc.vga_x) != ex || int'(ifc.vga_y) != ey || int'(ifc.vga_colour) != ec ||
                $isunknown({ifc.vga_x, ifc.vga_y, ifc.vga_colour})) begin
                n_bad++;
                $display("FAIL cycle_%0d: got plot=%0b done=%0b rdy=%0b x=%0d y=%0d c=%0d, want plot=%0b done=%0b rdy=%0b x=%0d y=%0d c=%0d",
                         cyc, ifc.vga_plot, ifc.done, ifc.req_ready, ifc.vga_x, ifc.vga_y, ifc.vga_colour,
                         ep, ed, er, ex, ey, ec);
            end
            if (ifc.vga_plot === 1'b1) begin
                plots.push_back('{x: int'(ifc.vga_x), y: int'(ifc.vga_y)});
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (ifc.done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_rec();
        plots.delete();
        first_cyc = -1;
        done_cyc  = -1;
        done_n    = 0;
    endtask

    // Present a request and hold it until accepted; optionally keep req_valid high.
    task automatic send(int x, int y, int s, int c, bit keep);
        int b;
        @(posedge clock); #1;
        ifc.req_valid  = 1'b1;
        ifc.req_x      = 8'(x);
        ifc.req_y      = 7'(y);
        ifc.req_size   = 2'(s);
        ifc.req_colour = 3'(c);
        b = 0;
        @(negedge clock);
        while (ifc.req_ready !== 1'b1 && b < 2000) begin
            b++;
            @(negedge clock);
        end
        if (b >= 2000) chk("accept_timeout", 0, 1);
        @(posedge clock);
        acc_cyc = cyc;
        #1;
        if (!keep) ifc.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (ifc.done !== 1'b1 && b < 2000) begin
            @(negedge clock);
            b++;
        end
        if (b >= 2000) chk("done_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        int b, cnt, d;
        reset          = 1'b1;
        ifc.req_valid  = 1'b0;
        ifc.req_x      = 8'd0;
        ifc.req_y      = 7'd0;
        ifc.req_size   = 2'd0;
        ifc.req_colour = 3'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_ready", int'(ifc.req_ready), 0);
        chk("reset_plot", int'(ifc.vga_plot), 0);
        chk("reset_done", int'(ifc.done), 0);
        chk("reset_x", int'(ifc.vga_x), 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", int'(ifc.req_ready), 1);

        // Big square fully on screen.
        clear_rec();
        send(10, 20, 2, 3'b100, 1'b0);
        wait_done();
        chk("big_count", plots.size(), 400);
        chk("big_p0_x", plots[0].x, 10);
        chk("big_p0_y", plots[0].y, 20);
        chk("big_p20_x", plots[20].x, 10);
        chk("big_p20_y", plots[20].y, 21);
        chk("big_p399_x", plots[399].x, 29);
        chk("big_p399_y", plots[399].y, 39);
        chk("big_done_n", done_n, 1);
        chk("big_done_latency", done_cyc - first_cyc, 400);
        chk("big_done_from_accept", done_cyc - acc_cyc, 401);

        // Small square order, then a single pixel in the corner.
        clear_rec();
        send(0, 0, 0, 3'b010, 1'b0);
        wait_done();
        chk("small_count", plots.size(), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("small_p%0d_x", k), plots[k].x, k % 4);
            chk($sformatf("small_p%0d_y", k), plots[k].y, k / 4);
        end
        clear_rec();
        send(159, 119, 3, 3'b111, 1'b0);
        wait_done();
        chk("single_count", plots.size(), 1);
        chk("single_x", plots[0].x, 159);
        chk("single_y", plots[0].y, 119);
        chk("single_done_n", done_n, 1);
        chk("single_done_from_accept", done_cyc - acc_cyc, 2);

        // Clipping against the bottom-right corner.
        clear_rec();
        send(150, 110, 2, 3'b001, 1'b0);
        wait_done();
        chk("clip_count", plots.size(), 100);
        chk("clip_done_from_accept", done_cyc - acc_cyc, 401);
        cnt = 0;
        foreach (plots[i]) if (plots[i].y == 10) cnt++;
        chk("clip_no_wrap_y", cnt, 0);

        // Back-to-back with req_valid held, and input churn during DRAW.
        clear_rec();
        send(20, 30, 1, 3'b010, 1'b1);
        ifc.req_x      = 8'd50;
        ifc.req_y      = 7'd60;
        ifc.req_size   = 2'd1;
        ifc.req_colour = 3'd5;
        wait_done();
        d = done_cyc;
        chk("b2b_first_count", plots.size(), 100);
        clear_rec();
        ifc.req_valid = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            ifc.req_x      = 8'($urandom_range(0, 255));
            ifc.req_colour = 3'($urandom_range(0, 7));
        end
        wait_done();
        chk("b2b_second_start", first_cyc - d, 2);
        chk("b2b_second_count", plots.size(), 100);
        chk("b2b_second_p0_x", plots[0].x, 50);
        chk("b2b_second_p0_y", plots[0].y, 60);

        // Reset in the middle of a medium square.
        clear_rec();
        send(30, 40, 1, 3'b110, 1'b0);
        b = 0;
        while (plots.size() < 57 && b < 1000) begin
            @(negedge clock); #1;
            b++;
        end
        if (b >= 1000) chk("mid_wait_timeout", 0, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_plot", int'(ifc.vga_plot), 0);
        chk("mid_reset_done", int'(ifc.done), 0);
        chk("mid_reset_ready", int'(ifc.req_ready), 0);
        repeat (2) @(posedge clock);
        #2;
        chk("mid_reset_ready_held", int'(ifc.req_ready), 0);
        reset = 1'b0;
        #1;
        chk("mid_release_ready", int'(ifc.req_ready), 1);
        chk("mid_no_done", done_n, 0);
        clear_rec();
        send(5, 6, 1, 3'b011, 1'b0);
        wait_done();
        chk("after_reset_count", plots.size(), 100);
        chk("after_reset_p0_x", plots[0].x, 5);
        chk("after_reset_p0_y", plots[0].y, 6);
        chk("after_reset_done_n", done_n, 1);

        // Randomized requests, including valid pulses while busy.
        repeat (4000) begin
            @(posedge clock); #1;
            ifc.req_valid  = ($urandom_range(0, 7) == 0);
            ifc.req_x      = 8'($urandom_range(0, 255));
            ifc.req_y      = 7'($urandom_range(0, 127));
            ifc.req_size   = 2'($urandom_range(0, 3));
            ifc.req_colour = 3'($urandom_range(0, 7));
        end
        ifc.req_valid = 1'b0;
        repeat (500) @(posedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
